// File: rtl/pc_sequencer.sv
// Fetch-stage program counter owner: one prioritized, registered path for every PC change
// (settle window, redirect, stall, sequential advance with end-of-memory wrap).
module pc_sequencer #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned PC_LIMIT    = 36,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Jump,
    input  logic [WIDTH-1:0] JumpTarget,
    output logic [WIDTH-1:0] PC,
    output logic             Valid,
    output logic             Flush,
    output logic [1:0]       State
);

    localparam int unsigned CNT_W = 4;
    localparam logic [WIDTH:0]   LIMIT      = (WIDTH+1)'(PC_LIMIT);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
    localparam logic [CNT_W-1:0] HOLD_INIT  = CNT_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t            state_q, state_nx;
    logic [CNT_W-1:0]  cnt_q, cnt_nx;
    logic [WIDTH-1:0]  pc_nx;
    logic              valid_nx;
    logic              flush_nx;
    logic [WIDTH:0]    seq_sum;

    // Any candidate past the memory bound, or one that carried out of WIDTH bits, restarts at 0.
    function automatic logic [WIDTH-1:0] bound(input logic [WIDTH:0] cand);
        bound = (cand[WIDTH] || (cand >= LIMIT)) ? '0 : cand[WIDTH-1:0];
    endfunction

    assign seq_sum = {1'b0, PC} + (WIDTH+1)'(4);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_HOLD;
            cnt_q   <= HOLD_INIT;
            PC      <= '0;
            Valid   <= 1'b0;
            Flush   <= 1'b0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            PC      <= pc_nx;
            Valid   <= valid_nx;
            Flush   <= flush_nx;
        end
    end

    assign State = state_q;

    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        pc_nx    = PC;
        valid_nx = Valid;
        flush_nx = 1'b0;

        case (state_q)
            ST_HOLD: begin
                // Settle window: inputs ignored, PC pinned to 0 until the counter drains.
                pc_nx    = '0;
                valid_nx = 1'b0;
                if (cnt_q == '0) begin
                    state_nx = ST_RUN;
                    valid_nx = 1'b1;
                end else begin
                    cnt_nx = cnt_q - CNT_W'(1);
                end
            end
            ST_RUN, ST_STALL: begin
                valid_nx = 1'b1;
                state_nx = ST_RUN;
                if (Jump) begin
                    pc_nx    = bound({1'b0, JumpTarget & ALIGN_MASK});
                    flush_nx = 1'b1;
                end else if (BranchTaken) begin
                    pc_nx    = bound({1'b0, BranchTarget & ALIGN_MASK});
                    flush_nx = 1'b1;
                end else if (Stall) begin
                    state_nx = ST_STALL;
                end else begin
                    pc_nx = bound(seq_sum);
                end
            end
            default: begin
                state_nx = ST_HOLD;
                cnt_nx   = HOLD_INIT;
                pc_nx    = '0;
                valid_nx = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: three instances (default, 3-cycle settle, 8-bit PC with carry wrap)
// checked every cycle against an edge-counting model, plus hand-computed spot values.
module tb_pc_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        BranchTaken;
    logic        Jump;
    logic [31:0] BranchTarget;
    logic [31:0] JumpTarget;

    logic [31:0] pc_a, pc_b;
    logic [7:0]  pc_c;
    logic        valid_a, valid_b, valid_c;
    logic        flush_a, flush_b, flush_c;
    logic [1:0]  state_a, state_b, state_c;

    int n_cmp = 0;
    int n_bad = 0;

    pc_sequencer #(.WIDTH(32), .PC_LIMIT(36), .HOLD_CYCLES(1)) dut_a (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
        .PC(pc_a), .Valid(valid_a), .Flush(flush_a), .State(state_a));

    pc_sequencer #(.WIDTH(32), .PC_LIMIT(36), .HOLD_CYCLES(3)) dut_b (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
        .PC(pc_b), .Valid(valid_b), .Flush(flush_b), .State(state_b));

    pc_sequencer #(.WIDTH(8), .PC_LIMIT(300), .HOLD_CYCLES(1)) dut_c (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget[7:0]), .Jump(Jump), .JumpTarget(JumpTarget[7:0]),
        .PC(pc_c), .Valid(valid_c), .Flush(flush_c), .State(state_c));

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Model parameters per instance
    int    hold_p[3] = '{1, 3, 1};
    int    width_p[3] = '{32, 32, 8};
    longint limit_p[3] = '{36, 36, 300};

    // Model state: counts edges since reset released instead of tracking an FSM
    longint m_pc[3];
    bit     m_valid[3];
    bit     m_flush[3];
    int     m_state[3];
    int     low_edges[3];

    longint dpc[3];
    longint dvalid[3];
    longint dflush[3];
    longint dstate[3];

    always_comb begin
        dpc[0] = longint'(pc_a);  dpc[1] = longint'(pc_b);  dpc[2] = longint'(pc_c);
        dvalid[0] = longint'(valid_a); dvalid[1] = longint'(valid_b); dvalid[2] = longint'(valid_c);
        dflush[0] = longint'(flush_a); dflush[1] = longint'(flush_b); dflush[2] = longint'(flush_c);
        dstate[0] = longint'(state_a); dstate[1] = longint'(state_b); dstate[2] = longint'(state_c);
    end

    function automatic longint fit(input longint v, input int i);
        longint span;
        span = longint'(1) << width_p[i];
        if (v >= span || v >= limit_p[i]) return 0;
        return v;
    endfunction

    task automatic model_edge(input int i);
        longint mask;
        mask = (longint'(1) << width_p[i]) - 1;
        m_flush[i] = 1'b0;
        if (Reset) begin
            low_edges[i] = 0;
            m_pc[i]      = 0;
            m_valid[i]   = 1'b0;
            m_state[i]   = 0;
        end else begin
            if (low_edges[i] < hold_p[i] + 2) low_edges[i]++;
            if (low_edges[i] <= hold_p[i]) begin
                m_pc[i] = 0; m_valid[i] = 1'b0; m_state[i] = 0;
            end else if (low_edges[i] == hold_p[i] + 1) begin
                m_pc[i] = 0; m_valid[i] = 1'b1; m_state[i] = 1;
            end else begin
                m_valid[i] = 1'b1;
                m_state[i] = 1;
                if (Jump) begin
                    m_pc[i] = fit(longint'(JumpTarget) & mask & ~longint'(3), i);
                    m_flush[i] = 1'b1;
                end else if (BranchTaken) begin
                    m_pc[i] = fit(longint'(BranchTarget) & mask & ~longint'(3), i);
                    m_flush[i] = 1'b1;
                end else if (Stall) begin
                    m_state[i] = 2;
                end else begin
                    m_pc[i] = fit(m_pc[i] + 4, i);
                end
            end
        end
    endtask

    task automatic chk(input string what, input int inst, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d @%0t: got %0d expected %0d", what, inst, $time, act, exp);
        end
    endtask

    always @(posedge Clk) begin
        for (int i = 0; i < 3; i++) model_edge(i);
    end

    // Per-cycle compare, one time unit after the edge
    always @(posedge Clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("pc", i, dpc[i], m_pc[i]);
            chk("valid", i, dvalid[i], longint'(m_valid[i]));
            chk("flush", i, dflush[i], longint'(m_flush[i]));
            chk("state", i, dstate[i], longint'(m_state[i]));
        end
    end

    task automatic step(input logic st, input logic bt, input logic [31:0] btg,
                        input logic j, input logic [31:0] jt);
        Stall = st; BranchTaken = bt; BranchTarget = btg; Jump = j; JumpTarget = jt;
        @(negedge Clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; Jump = 1'b0;
        BranchTarget = '0; JumpTarget = '0;
        @(negedge Clk);
        @(negedge Clk);
        chk("lit_reset_pc", 0, longint'(pc_a), 0);
        chk("lit_reset_valid", 0, longint'(valid_a), 0);
        Reset = 1'b0;

        idle(1);
        chk("lit_hold_valid", 0, longint'(valid_a), 0);
        chk("lit_hold_state", 0, longint'(state_a), 0);
        idle(1);
        chk("lit_run_valid", 0, longint'(valid_a), 1);
        chk("lit_run_pc0", 0, longint'(pc_a), 0);
        chk("lit_run_state", 0, longint'(state_a), 1);
        idle(8);
        chk("lit_pc32", 0, longint'(pc_a), 32);
        idle(1);
        chk("lit_wrap0", 0, longint'(pc_a), 0);
        chk("lit_c_no_wrap", 2, longint'(pc_c), 36);
        idle(2);
        chk("lit_pc8", 0, longint'(pc_a), 8);

        // Stall for three cycles at PC=8
        step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("lit_stall_pc", 0, longint'(pc_a), 8);
        chk("lit_stall_state", 0, longint'(state_a), 2);
        chk("lit_stall_flush", 0, longint'(flush_a), 0);
        idle(1);
        chk("lit_release_pc", 0, longint'(pc_a), 12);
        chk("lit_release_state", 0, longint'(state_a), 1);

        // Jump beats branch in the same cycle
        step(1'b0, 1'b1, 32'd20, 1'b1, 32'd28);
        chk("lit_jump_pc", 0, longint'(pc_a), 28);
        chk("lit_jump_flush", 0, longint'(flush_a), 1);
        idle(1);
        chk("lit_after_jump_pc", 0, longint'(pc_a), 32);
        chk("lit_after_jump_flush", 0, longint'(flush_a), 0);

        step(1'b0, 1'b1, 32'd40, 1'b0, 32'd0);
        chk("lit_branch_wrap", 0, longint'(pc_a), 0);
        step(1'b0, 1'b1, 32'h13, 1'b0, 32'd0);
        chk("lit_branch_align", 0, longint'(pc_a), 16);
        chk("lit_b2b_flush", 0, longint'(flush_a), 1);

        // Jump arriving during stall
        step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("lit_stall2_state", 0, longint'(state_a), 2);
        step(1'b1, 1'b0, 32'd0, 1'b1, 32'd8);
        chk("lit_stall_jump_pc", 0, longint'(pc_a), 8);
        chk("lit_stall_jump_state", 0, longint'(state_a), 1);
        idle(3);
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'd24);
        chk("lit_pc24", 0, longint'(pc_a), 24);

        // Reset together with a jump while a flush is pending
        Reset = 1'b1;
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'd4);
        chk("lit_mid_reset_pc", 0, longint'(pc_a), 0);
        chk("lit_mid_reset_valid", 0, longint'(valid_a), 0);
        chk("lit_mid_reset_flush", 0, longint'(flush_a), 0);
        chk("lit_mid_reset_state", 0, longint'(state_a), 0);
        Reset = 1'b0;

        // Jumps pulsed through the 3-cycle settle window of instance b
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'd12);
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'd12);
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'd12);
        chk("lit_b_hold_valid", 1, longint'(valid_b), 0);
        chk("lit_b_hold_pc", 1, longint'(pc_b), 0);
        chk("lit_a_jump_after_hold", 0, longint'(pc_a), 12);
        idle(1);
        chk("lit_b_valid", 1, longint'(valid_b), 1);
        chk("lit_b_pc0", 1, longint'(pc_b), 0);
        idle(1);
        chk("lit_b_pc4", 1, longint'(pc_b), 4);

        // Carry-out wrap on the 8-bit instance
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'd252);
        chk("lit_c_pc252", 2, longint'(pc_c), 252);
        chk("lit_a_jump_oob", 0, longint'(pc_a), 0);
        idle(1);
        chk("lit_c_carry_wrap", 2, longint'(pc_c), 0);
        idle(1);
        chk("lit_c_pc4", 2, longint'(pc_c), 4);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
